// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   Leaky integrate-and-fire stage. It takes one unsigned current per neuron per
//   timestep, in neuron index order. It keeps a membrane potential and a
//   saturating spike count for each neuron, and publishes the spike vector of
//   the timestep once the last neuron has been updated.
//
//   Optional feature macro: LIF_REFRAC_EN. When it is defined, each neuron has a
//   refractory counter. While that counter is nonzero, the neuron's potential is
//   held at V_RESET and the neuron cannot fire.
//
// Ports
//   clk, reset_n   clock; asynchronous active-low reset
//   i_start_step   pulse in idle: begin collecting one timestep of currents
//   i_clear        pulse in idle: zero potentials, counts, refractory state and o_spike
//   i_current      current for the neuron currently being indexed
//   i_valid        qualifies i_current
//   o_spike        spike vector of the last completed timestep
//   o_spike_valid  1-cycle pulse when o_spike carries a new vector
//   o_done         1-cycle pulse at the end of a timestep or at the end of a clear
//   o_busy         high in any state other than S_IDLE
//   o_spike_cnt    per-neuron spike counts; neuron k is at [k*CNT_W +: CNT_W]
//
// state  | meaning
// S_IDLE | waiting for i_start_step or i_clear
// S_ACC  | consuming currents; one neuron is updated per i_valid
// S_FIRE | o_spike holds the new vector; valid and done pulse
// S_CLR  | zeroing all neuron state
module lif_neuron_array #(
  parameter int N_NEURON     = 18,
  parameter int CUR_W        = 25,
  parameter int VMEM_W       = 26,
  parameter int THRESH       = 20000,
  parameter int LEAK_SHIFT   = 4,
  parameter int V_RESET      = 0,
  parameter int CNT_W        = 8,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_start_step,
  input  logic                      i_clear,
  input  logic [CUR_W-1:0]          i_current,
  input  logic                      i_valid,
  output logic [N_NEURON-1:0]       o_spike,
  output logic                      o_spike_valid,
  output logic                      o_done,
  output logic                      o_busy,
  output logic [N_NEURON*CNT_W-1:0] o_spike_cnt
);

  localparam int IDX_W = $clog2(N_NEURON);
  localparam logic [VMEM_W-1:0] THRESH_V  = VMEM_W'(THRESH);
  localparam logic [VMEM_W-1:0] V_RESET_V = VMEM_W'(V_RESET);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_NEURON - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIRE, S_CLR} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VMEM_W-1:0]     v_q [N_NEURON];
  logic [VMEM_W-1:0]     v_d [N_NEURON];
  logic [CNT_W-1:0]      cnt_q [N_NEURON];
  logic [CNT_W-1:0]      cnt_d [N_NEURON];
  logic [N_NEURON-1:0]   work_q, work_d;
  logic [N_NEURON-1:0]   spike_q, spike_d;

  // Datapath for the neuron that idx_q currently selects. The extra top bit of
  // v_sum catches overflow. The leak term never exceeds v, so the subtraction
  // cannot go below zero.
  logic [VMEM_W-1:0]     v_cur;
  logic [VMEM_W:0]       v_sum;
  logic [VMEM_W-1:0]     v_new;
  logic                  fire;

`ifdef LIF_REFRAC_EN
  localparam int RC_W = $clog2(REFRAC_STEPS + 1);
  logic [RC_W-1:0]       rc_q [N_NEURON];
  logic [RC_W-1:0]       rc_d [N_NEURON];
`endif

  always_comb begin
    v_cur = v_q[idx_q];
    v_sum = {1'b0, v_cur} - {1'b0, (v_cur >> LEAK_SHIFT)} + (VMEM_W+1)'(i_current);
    v_new = v_sum[VMEM_W] ? '1 : v_sum[VMEM_W-1:0];
    fire  = (v_new >= THRESH_V);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    spike_d = spike_q;
`ifdef LIF_REFRAC_EN
    rc_d    = rc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_clear) begin
          state_d = S_CLR;
        end else if (i_start_step) begin
          state_d = S_ACC;
          idx_d   = '0;
          work_d  = '0;
        end
      end
      S_ACC: begin
        if (i_valid) begin
`ifdef LIF_REFRAC_EN
          if (rc_q[idx_q] != '0) begin
            // Refractory: the neuron neither integrates nor fires this timestep.
            rc_d[idx_q]   = rc_q[idx_q] - 1'b1;
            v_d[idx_q]    = V_RESET_V;
            work_d[idx_q] = 1'b0;
          end else
`endif
          if (fire) begin
            work_d[idx_q] = 1'b1;
            v_d[idx_q]    = V_RESET_V;
            if (cnt_q[idx_q] != '1) cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
`ifdef LIF_REFRAC_EN
            rc_d[idx_q]   = RC_W'(REFRAC_STEPS);
`endif
          end else begin
            work_d[idx_q] = 1'b0;
            v_d[idx_q]    = v_new;
          end
          if (idx_q == IDX_LAST) begin
            // o_spike is loaded together with the last update, so it is
            // already valid in the S_FIRE cycle that pulses o_spike_valid.
            state_d = S_FIRE;
            idx_d   = '0;
            spike_d = work_d;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FIRE: state_d = S_IDLE;
      S_CLR: begin
        state_d = S_IDLE;
        v_d     = '{default: '0};
        cnt_d   = '{default: '0};
        work_d  = '0;
        spike_d = '0;
`ifdef LIF_REFRAC_EN
        rc_d    = '{default: '0};
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      v_q     <= '{default: '0};
      cnt_q   <= '{default: '0};
      work_q  <= '0;
      spike_q <= '0;
`ifdef LIF_REFRAC_EN
      rc_q    <= '{default: '0};
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      spike_q <= spike_d;
`ifdef LIF_REFRAC_EN
      rc_q    <= rc_d;
`endif
    end
  end

  assign o_spike       = spike_q;
  assign o_spike_valid = (state_q == S_FIRE);
  assign o_done        = (state_q == S_FIRE) || (state_q == S_CLR);
  assign o_busy        = (state_q != S_IDLE);

  for (genvar k = 0; k < N_NEURON; k++) begin : g_cnt
    assign o_spike_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule
